traffic_light_ctrl: RTL
=======================

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 SHALL provide parameter CNT_W, default 16, phase counter width.
REQ-002 SHALL provide parameter GREEN_TICS, default 200, full green duration in ticks.
REQ-003 SHALL provide parameter MIN_GREEN_TICS, default 50, minimum green before a pedestrian cut-short.
REQ-004 SHALL provide parameter AMBER_TICS, default 30, amber duration.
REQ-005 SHALL provide parameter ALLRED_TICS, default 10, all-red clearance duration.
REQ-006 SHALL provide parameter WALK_TICS, default 60, pedestrian walk duration.
REQ-007 SHALL provide parameter FLASH_TICS, default 20, half-period of night amber flash.
REQ-008 SHALL provide port clk  in  1  sole clock, rising edge.
REQ-009 SHALL provide port rst_n  in  1  reset, asynchronous, active-low.
REQ-010 SHALL provide port tick_en  in  1  timebase strobe; all timing counts only cycles with tick_en=1.
REQ-011 SHALL provide port ped_req  in  1  pedestrian request, level, sampled every cycle.
REQ-012 SHALL provide port night_mode  in  1  selects flashing-amber operation.
REQ-013 SHALL provide port ns_light  out  3  north-south {red,amber,green}, registered.
REQ-014 SHALL provide port ew_light  out  3  east-west {red,amber,green}, registered.
REQ-015 SHALL provide port ped_walk  out  1  walk signal, registered.
REQ-016 SHALL provide port state_o  out  3  current state code, for debug.

Function
REQ-017 SHALL implement states NS_GREEN, NS_AMBER, ALLRED_A, EW_GREEN, EW_AMBER, ALLRED_B, PED_WALK, FLASH.
REQ-018 SHALL clear the elapsed-tick counter on every state entry and increment it on tick_en; a state exits on the tick_en cycle where elapsed==DUR-1.
REQ-019 SHALL sequence NS_GREEN->NS_AMBER->ALLRED_A->EW_GREEN->EW_AMBER->ALLRED_B->NS_GREEN.
REQ-020 SHALL set a sticky ped_pend flag on any cycle ped_req=1; cleared only on exit from PED_WALK.
REQ-021 SHALL, in a green state with ped_pend=1, exit to amber on the tick_en cycle where elapsed>=MIN_GREEN_TICS-1 (immediately if already past).
REQ-022 SHALL, on ALLRED_A or ALLRED_B exit with ped_pend=1, enter PED_WALK (all red, ped_walk=1, WALK_TICS), then resume the green that ALLRED would have entered.
REQ-023 SHALL sample night_mode only at ALLRED_A/ALLRED_B exit; if 1, enter FLASH, taking priority over PED_WALK.
REQ-024 SHALL, in FLASH, drive red=0/green=0 on both roads and toggle both ambers together every FLASH_TICS, starting with ambers on.
REQ-025 SHALL exit FLASH to ALLRED_B when night_mode=0 at a flash half-period boundary; ped_pend is held, not cleared, during FLASH.
REQ-026 SHALL never drive green or amber on both roads simultaneously except amber in FLASH; ped_walk=1 only in PED_WALK.
REQ-027 SHALL update outputs in the same clock edge as the state register (no combinational output path).
REQ-028 SHALL hold all state and counters when tick_en=0.
REQ-029 SHALL require every *_TICS >=1, MIN_GREEN_TICS<=GREEN_TICS, and all values < 2**CNT_W (elaboration assertion).

Reset
REQ-030 SHALL, on rst_n=0, asynchronously enter ALLRED_B with counter=0 and ped_pend=0.
REQ-031 SHALL drive ns_light=3'b100, ew_light=3'b100, ped_walk=0 during and immediately after reset.
REQ-032 SHALL abort any phase mid-operation on reset assertion with no intermediate output glitch beyond the all-red value.

Structure
REQ-033 SHALL place the state enum and the light encodings (RED=3'b100, AMBER=3'b010, GREEN=3'b001, OFF=3'b000) in package traffic_pkg.
REQ-034 SHALL use one sub-module tl_phase_timer (clear, tick_en, elapsed count, done compare) instantiated once.

Verification (tick_en=1 constant, GREEN=8, MIN_GREEN=4, AMBER=3, ALLRED=2, WALK=5, FLASH=2)
REQ-035 SHALL check reset release -> 2 cycles all red, then ns green 8, ns amber 3, all red 2, ew green 8.
REQ-036 SHALL check ped_req pulse at NS_GREEN cycle 1 -> ns green exactly 4 cycles, amber 3, all red 2, PED_WALK 5 with ped_walk=1, then EW_GREEN.
REQ-037 SHALL check ped_req at NS_GREEN cycle 6 -> amber at next cycle (green 7 total).
REQ-038 SHALL check night_mode=1 during EW_GREEN -> cycle completes to ALLRED_B, then ambers on 2/off 2 repeating; drop night_mode -> ALLRED_B 2 then NS_GREEN.
REQ-039 SHALL check tick_en=1 every 4th cycle -> every phase lasts 4x its cycles.
REQ-040 SHALL check rst_n low mid EW_AMBER -> outputs all red same edge, ped_pend cleared; conflict assertion (REQ-026) holds throughout.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: state encoding, light encodings and output decode for the traffic controller
package traffic_pkg;
  typedef enum logic [2:0] {
    NS_GREEN = 3'd0,
    NS_AMBER = 3'd1,
    ALLRED_A = 3'd2,
    EW_GREEN = 3'd3,
    EW_AMBER = 3'd4,
    ALLRED_B = 3'd5,
    PED_WALK = 3'd6,
    FLASH    = 3'd7
  } state_t;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] AMBER = 3'b010;
  localparam logic [2:0] GREEN = 3'b001;
  localparam logic [2:0] OFF   = 3'b000;
  function automatic logic [6:0] lights(input state_t s, input logic flash_on);
    case (s)
      NS_GREEN: return {GREEN, RED, 1'b0};
      NS_AMBER: return {AMBER, RED, 1'b0};
      EW_GREEN: return {RED, GREEN, 1'b0};
      EW_AMBER: return {RED, AMBER, 1'b0};
      PED_WALK: return {RED, RED, 1'b1};
      FLASH:    return flash_on ? {AMBER, AMBER, 1'b0} : {OFF, OFF, 1'b0};
      default:  return {RED, RED, 1'b0};
    endcase
  endfunction
endpackage

// File: rtl/tl_phase_timer.sv
// tl_phase_timer: elapsed-tick counter per phase with end-of-phase compare
module tl_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             tick_en,
  input  logic [CNT_W-1:0] dur,
  output logic [CNT_W-1:0] elapsed,
  output logic             done
);
  assign done = tick_en && elapsed == dur - CNT_W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) elapsed <= '0;
    else elapsed <= clr ? '0 : tick_en ? elapsed + CNT_W'(1) : elapsed;
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road signal sequencer with pedestrian phase and night flashing
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int GREEN_TICS     = 200,
  parameter int MIN_GREEN_TICS = 50,
  parameter int AMBER_TICS     = 30,
  parameter int ALLRED_TICS    = 10,
  parameter int WALK_TICS      = 60,
  parameter int FLASH_TICS     = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_en,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ped_walk,
  output logic [2:0] state_o
);
  localparam longint LIM = longint'(1) << CNT_W;
  if (GREEN_TICS < 1 || MIN_GREEN_TICS < 1 || AMBER_TICS < 1 || ALLRED_TICS < 1 ||
      WALK_TICS < 1 || FLASH_TICS < 1 || MIN_GREEN_TICS > GREEN_TICS ||
      GREEN_TICS >= LIM || AMBER_TICS >= LIM || ALLRED_TICS >= LIM ||
      WALK_TICS >= LIM || FLASH_TICS >= LIM) begin : g_bad_params
    $fatal(1, "traffic_light_ctrl: illegal timing parameters");
  end
  state_t state, nxt;
  logic flash_on, nxt_flash, ped_pend, ped_ns, pend, cut, adv, done;
  logic [CNT_W-1:0] elapsed, dur;
  assign pend = ped_pend | ped_req;
  assign cut = pend && tick_en && elapsed >= CNT_W'(MIN_GREEN_TICS - 1);
  assign nxt_flash = nxt == FLASH && !(state == FLASH && flash_on);
  assign state_o = state;
  assign dur = state inside {NS_GREEN, EW_GREEN} ? CNT_W'(GREEN_TICS)
             : state inside {NS_AMBER, EW_AMBER} ? CNT_W'(AMBER_TICS)
             : state == PED_WALK ? CNT_W'(WALK_TICS)
             : state == FLASH ? CNT_W'(FLASH_TICS) : CNT_W'(ALLRED_TICS);
  tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk), .rst_n(rst_n), .clr(adv), .tick_en(tick_en),
    .dur(dur), .elapsed(elapsed), .done(done)
  );
  // adv doubles as the timer clear, including each flash half-period
  always_comb begin
    adv = done;
    nxt = state;
    case (state)
      NS_GREEN: begin adv = done | cut; nxt = NS_AMBER; end
      NS_AMBER: nxt = ALLRED_A;
      ALLRED_A, ALLRED_B: nxt = night_mode ? FLASH : pend ? PED_WALK
                              : state == ALLRED_A ? EW_GREEN : NS_GREEN;
      EW_GREEN: begin adv = done | cut; nxt = EW_AMBER; end
      EW_AMBER: nxt = ALLRED_B;
      PED_WALK: nxt = ped_ns ? NS_GREEN : EW_GREEN;
      default:  nxt = night_mode ? FLASH : ALLRED_B;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= ALLRED_B;
      flash_on <= 1'b0;
      ped_pend <= 1'b0;
      ped_ns   <= 1'b0;
      ns_light <= RED;
      ew_light <= RED;
      ped_walk <= 1'b0;
    end else begin
      ped_pend <= (state == PED_WALK && adv) ? 1'b0 : pend;
      if (adv) begin
        state    <= nxt;
        flash_on <= nxt_flash;
        if (nxt == PED_WALK) ped_ns <= state == ALLRED_B;
        {ns_light, ew_light, ped_walk} <= lights(nxt, nxt_flash);
      end
    end
endmodule
